timer_bank: RTL and testbench



---
 rtl/timer_bank_if.sv | 25 ++
 rtl/timer_bank.sv | 195 +++++++++++++++++++
 tb/tb_timer_bank.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank_if
//  Description : MCU register-write bus feeding the timer bank. One write per
//                clock with mcuWe high; the register decoder is the master.
//  Revision    : 1.0  initial release
// ============================================================================
interface timer_bank_if;
   logic        mcuWe;
   logic [3:0]  mcuRegSelect;
   logic [15:0] mcuWriteData;

   modport master (
      output mcuWe,
      output mcuRegSelect,
      output mcuWriteData
   );

   modport slave (
      input  mcuWe,
      input  mcuRegSelect,
      input  mcuWriteData
   );
endinterface : timer_bank_if
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank
//  Description : Shared 16-bit DIV prescaler plus NUM_CH independent
//                TIMA/TMA/TAC channels with falling-edge counting, one-tick
//                delayed overflow reload, write-cancel and a one-clock
//                interrupt pulse per channel.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_bank #(
   parameter int          NUM_CH   = 2,
   parameter int          CNT_W    = 8,
   parameter logic [15:0] DIV_INIT = 16'hD300
) (
   input  logic                      iClock,
   input  logic                      iReset_n,
   input  logic                      iTick,
   timer_bank_if.slave               mcuBus,
   output logic [7:0]                oDiv,
   output logic [NUM_CH*CNT_W-1:0]   oTima,
   output logic [NUM_CH*CNT_W-1:0]   oModulo,
   output logic [NUM_CH*8-1:0]       oTac,
   output logic [NUM_CH-1:0]         oInterrupt
);

   // Channel states: counting, overflowed (TIMA reads 0), reload window.
   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_OVF    = 2'd1;
   localparam logic [1:0] ST_RELOAD = 2'd2;

   localparam logic [3:0]       cSelDiv = 4'd0;
   localparam logic [CNT_W-1:0] cMax    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] cOne    = CNT_W'(1);

   logic [15:0] rPrescaler;
   logic [15:0] wPrescalerNext;
   logic        wDivWrite;
   logic [CNT_W-1:0] wData;
   logic        unusedBits;

   assign wDivWrite  = mcuBus.mcuWe && (mcuBus.mcuRegSelect == cSelDiv);
   assign wData      = mcuBus.mcuWriteData[CNT_W-1:0];
   // Upper data bits are dropped when CNT_W < 16; folded here on purpose.
   assign unusedBits = ^mcuBus.mcuWriteData;

   // Next prescaler value: a DIV write clears it and beats a same-cycle tick.
   always_comb begin
      wPrescalerNext = rPrescaler;
      if (wDivWrite) begin
         wPrescalerNext = '0;
      end else if (iTick) begin
         wPrescalerNext = rPrescaler + 16'd1;
      end
   end

   // Prescaler register.
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         rPrescaler <= DIV_INIT;
      end else begin
         rPrescaler <= wPrescalerNext;
      end
   end

   assign oDiv = rPrescaler[15:8];

   generate
      for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
         localparam logic [3:0] cSelTima = 4'(1 + 3*n);
         localparam logic [3:0] cSelTma  = 4'(2 + 3*n);
         localparam logic [3:0] cSelTac  = 4'(3 + 3*n);

         logic [CNT_W-1:0] rTima;
         logic [CNT_W-1:0] rTma;
         logic [2:0]       rTac;
         logic [1:0]       rState;
         logic             rPrev;
         logic             rIrq;

         logic [CNT_W-1:0] wTimaNext;
         logic [CNT_W-1:0] wTmaNext;
         logic [1:0]       wStateNext;
         logic             wIrqNext;
         logic [CNT_W-1:0] wTimaInc;
         logic             wWrap;
         logic             wWeTima;
         logic             wWeTma;
         logic             wWeTac;
         logic [2:0]       wTacNext;
         logic             wSelBit;
         logic             wSig;
         logic             wFall;

         assign wWeTima = mcuBus.mcuWe && (mcuBus.mcuRegSelect == cSelTima);
         assign wWeTma  = mcuBus.mcuWe && (mcuBus.mcuRegSelect == cSelTma);
         assign wWeTac  = mcuBus.mcuWe && (mcuBus.mcuRegSelect == cSelTac);

         // The timer signal is built from next-state prescaler and TAC so that
         // the increment lands on the same edge as the causing transition, and
         // DIV/TAC writes produce the classic glitch increments.
         assign wTacNext = wWeTac ? mcuBus.mcuWriteData[2:0] : rTac;

         // Prescaler tap selected by TAC[1:0].
         always_comb begin
            case (wTacNext[1:0])
               2'b00:   wSelBit = wPrescalerNext[9];
               2'b01:   wSelBit = wPrescalerNext[3];
               2'b10:   wSelBit = wPrescalerNext[5];
               default: wSelBit = wPrescalerNext[7];
            endcase
         end

         assign wSig     = wTacNext[2] & wSelBit;
         assign wFall    = rPrev & ~wSig;
         assign wWrap    = (rTima == cMax);
         assign wTimaInc = wWrap ? '0 : (rTima + cOne);

         // Channel FSM next-state: writes beat increments; an overflow holds
         // TIMA at 0 for one tick before loading TMA and pulsing the IRQ.
         always_comb begin
            wTimaNext  = rTima;
            wTmaNext   = rTma;
            wStateNext = rState;
            wIrqNext   = 1'b0;
            if (wWeTma) begin
               wTmaNext = wData;
            end
            case (rState)
               ST_RUN: begin
                  if (wWeTima) begin
                     wTimaNext = wData;
                  end else if (wFall) begin
                     wTimaNext = wTimaInc;
                     if (wWrap) begin
                        wStateNext = ST_OVF;
                     end
                  end
               end
               ST_OVF: begin
                  if (wWeTima) begin
                     wTimaNext  = wData;
                     wStateNext = ST_RUN;
                  end else if (iTick) begin
                     wTimaNext  = wTmaNext;
                     wIrqNext   = 1'b1;
                     wStateNext = ST_RELOAD;
                  end
               end
               ST_RELOAD: begin
                  if (iTick) begin
                     wStateNext = ST_RUN;
                  end
                  if (wWeTma) begin
                     wTimaNext = wData;
                  end else if (wFall) begin
                     wTimaNext = wTimaInc;
                     if (wWrap) begin
                        wStateNext = ST_OVF;
                     end
                  end
               end
               default: begin
                  wStateNext = ST_RUN;
               end
            endcase
         end

         // Channel registers.
         always_ff @(posedge iClock or negedge iReset_n) begin
            if (!iReset_n) begin
               rTima  <= '0;
               rTma   <= '0;
               rTac   <= '0;
               rState <= ST_RUN;
               rPrev  <= 1'b0;
               rIrq   <= 1'b0;
            end else begin
               rTima  <= wTimaNext;
               rTma   <= wTmaNext;
               rTac   <= wTacNext;
               rState <= wStateNext;
               rPrev  <= wSig;
               rIrq   <= wIrqNext;
            end
         end

         assign oTima[n*CNT_W +: CNT_W]   = rTima;
         assign oModulo[n*CNT_W +: CNT_W] = rTma;
         assign oTac[n*8 +: 8]            = {5'b11111, rTac};
         assign oInterrupt[n]             = rIrq;
      end
   endgenerate

endmodule : timer_bank
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_bank
//  Description : Scoreboard bench for timer_bank. Stimulus pushes expected
//                register values and interrupt pulses into queues; a monitor
//                on the falling clock edge pops and compares them. Two DUTs:
//                A (CNT_W=8) and B (CNT_W=16), both with NUM_CH=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_bank;

   logic iClock   = 1'b0;
   logic iReset_n = 1'b0;
   logic iTick    = 1'b0;
   int   cycleCnt = 0;
   int   nVec     = 0;
   int   nFail    = 0;

   timer_bank_if busA ();
   timer_bank_if busB ();

   logic [7:0]  divA;
   logic [15:0] timaA, tmaA, tacA;
   logic [1:0]  irqA;
   logic [7:0]  divB;
   logic [31:0] timaB, tmaB;
   logic [15:0] tacB;
   logic [1:0]  irqB;

   timer_bank #(.NUM_CH(2), .CNT_W(8), .DIV_INIT(16'hD300)) dutA (
      .iClock(iClock), .iReset_n(iReset_n), .iTick(iTick), .mcuBus(busA),
      .oDiv(divA), .oTima(timaA), .oModulo(tmaA), .oTac(tacA), .oInterrupt(irqA)
   );

   timer_bank #(.NUM_CH(2), .CNT_W(16), .DIV_INIT(16'hD300)) dutB (
      .iClock(iClock), .iReset_n(iReset_n), .iTick(iTick), .mcuBus(busB),
      .oDiv(divB), .oTima(timaB), .oModulo(tmaB), .oTac(tacB), .oInterrupt(irqB)
   );

   always #5 iClock = ~iClock;

   always @(posedge iClock) cycleCnt <= cycleCnt + 1;

   localparam int K_DIV = 0, K_TIMA = 1, K_TMA = 2, K_TAC = 3, K_IRQ = 4;

   typedef struct {
      int    cyc;
      int    dut;
      int    kind;
      int    ch;
      int    exp;
      string name;
   } exp_t;

   typedef struct {
      int cyc;
      int exp;
   } irq_t;

   exp_t q[$];
   irq_t irqQA[$];
   irq_t irqQB[$];

   function automatic int actual(input int dut, input int kind, input int ch);
      if (dut == 0) begin
         case (kind)
            K_DIV:   return int'(divA);
            K_TIMA:  return int'(timaA[ch*8 +: 8]);
            K_TMA:   return int'(tmaA[ch*8 +: 8]);
            K_TAC:   return int'(tacA[ch*8 +: 8]);
            default: return int'(irqA);
         endcase
      end else begin
         case (kind)
            K_DIV:   return int'(divB);
            K_TIMA:  return int'(timaB[ch*16 +: 16]);
            K_TMA:   return int'(tmaB[ch*16 +: 16]);
            K_TAC:   return int'(tacB[ch*8 +: 8]);
            default: return int'(irqB);
         endcase
      end
   endfunction

   // Monitor: compares queued register expectations and every interrupt pulse.
   always @(negedge iClock) begin : p_monitor
      exp_t       e;
      irq_t       head;
      int         act;
      logic [1:0] irqNow;
      bit         have;
      while (q.size() > 0 && q[0].cyc <= cycleCnt) begin
         e   = q.pop_front();
         act = actual(e.dut, e.kind, e.ch);
         nVec++;
         if (e.cyc != cycleCnt) begin
            nFail++;
            $display("FAIL %s: check not reached in its cycle, expected 0x%0h", e.name, e.exp);
         end else if (act != e.exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, act, e.exp, cycleCnt);
         end
      end
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            irqNow = irqA;
            have   = (irqQA.size() > 0);
            if (have) head = irqQA[0];
         end else begin
            irqNow = irqB;
            have   = (irqQB.size() > 0);
            if (have) head = irqQB[0];
         end
         if (have && head.cyc <= cycleCnt) begin
            if (d == 0) void'(irqQA.pop_front());
            else        void'(irqQB.pop_front());
            nVec++;
            if (head.cyc < cycleCnt) begin
               nFail++;
               $display("FAIL irq dut%0d: pulse 0x%0h never seen at cycle %0d", d, head.exp, head.cyc);
            end else if (int'(irqNow) != head.exp) begin
               nFail++;
               $display("FAIL irq dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", d, irqNow, head.exp, cycleCnt);
            end
         end else if (irqNow != 2'b00) begin
            nVec++;
            nFail++;
            $display("FAIL irq dut%0d: got 0x%0h, expected 0x0 (cycle %0d)", d, irqNow, cycleCnt);
         end
      end
   end

   task automatic cyc1();
      @(posedge iClock);
      #1;
   endtask

   task automatic wr(input int dut, input int sel, input int data);
      if (dut == 0) begin
         busA.mcuWe = 1'b1; busA.mcuRegSelect = sel[3:0]; busA.mcuWriteData = data[15:0];
      end else begin
         busB.mcuWe = 1'b1; busB.mcuRegSelect = sel[3:0]; busB.mcuWriteData = data[15:0];
      end
      cyc1();
      busA.mcuWe = 1'b0;
      busB.mcuWe = 1'b0;
   endtask

   task automatic tick(input int n);
      iTick = 1'b1;
      repeat (n) cyc1();
      iTick = 1'b0;
   endtask

   task automatic expectNow(input int dut, input int kind, input int ch, input int val, input string name);
      exp_t e;
      e.cyc = cycleCnt; e.dut = dut; e.kind = kind; e.ch = ch; e.exp = val; e.name = name;
      q.push_back(e);
   endtask

   task automatic expectIrq(input int dut, input int val);
      irq_t e;
      e.cyc = cycleCnt; e.exp = val;
      if (dut == 0) irqQA.push_back(e);
      else          irqQB.push_back(e);
   endtask

   // Arm dut A channel 0 so it overflows on the 32nd tick after a DIV clear.
   task automatic armOverflowA();
      wr(0, 1, 'hFE);
      wr(0, 0, 0);
   endtask

   initial begin
      busA.mcuWe = 1'b0; busA.mcuRegSelect = 4'd0; busA.mcuWriteData = 16'd0;
      busB.mcuWe = 1'b0; busB.mcuRegSelect = 4'd0; busB.mcuWriteData = 16'd0;
      repeat (3) cyc1();
      iReset_n = 1'b1;
      cyc1();

      // Values straight out of reset
      expectNow(0, K_DIV,  0, 'hD3, "rst div");
      expectNow(0, K_TIMA, 0, 'h00, "rst tima0");
      expectNow(0, K_TMA,  0, 'h00, "rst tma0");
      expectNow(0, K_TAC,  0, 'hF8, "rst tac0");
      expectNow(0, K_TAC,  1, 'hF8, "rst tac1");

      // Counting rate, tac=5 then tac=4
      wr(0, 3, 5);
      wr(0, 0, 0);
      wr(0, 1, 0);
      expectNow(0, K_TAC, 0, 'hFD, "tac0=5");
      tick(15); expectNow(0, K_TIMA, 0, 0, "tac5 tick15");
      tick(1);  expectNow(0, K_TIMA, 0, 1, "tac5 tick16");
      tick(16); expectNow(0, K_TIMA, 0, 2, "tac5 tick32");
      wr(0, 3, 4);
      wr(0, 0, 0);
      wr(0, 1, 0);
      tick(1023); expectNow(0, K_TIMA, 0, 0, "tac4 tick1023");
      tick(1);    expectNow(0, K_TIMA, 0, 1, "tac4 tick1024");
      expectNow(0, K_DIV, 0, 'h04, "div after 1024");

      // Overflow and delayed reload
      wr(0, 2, 'hF0);
      wr(0, 3, 5);
      armOverflowA();
      expectNow(0, K_TMA, 0, 'hF0, "tma0 write");
      tick(16); expectNow(0, K_TIMA, 0, 'hFF, "ovf tick16");
      tick(16); expectNow(0, K_TIMA, 0, 'h00, "ovf tick32");
      tick(1);  expectNow(0, K_TIMA, 0, 'hF0, "reload tick33"); expectIrq(0, 1);
      tick(1);  expectNow(0, K_TIMA, 0, 'hF0, "back to run");

      // TIMA write during overflow cancels reload and IRQ
      armOverflowA();
      tick(32); expectNow(0, K_TIMA, 0, 'h00, "cancel pre");
      wr(0, 1, 'h10); expectNow(0, K_TIMA, 0, 'h10, "cancel write");
      tick(1);  expectNow(0, K_TIMA, 0, 'h10, "cancel no reload");

      // TIMA write during reload window is ignored
      armOverflowA();
      tick(33); expectNow(0, K_TIMA, 0, 'hF0, "reload2"); expectIrq(0, 1);
      wr(0, 1, 'h10); expectNow(0, K_TIMA, 0, 'hF0, "reload tima wr ignored");
      tick(1);  expectNow(0, K_TIMA, 0, 'hF0, "reload2 run");
      wr(0, 1, 'h20); expectNow(0, K_TIMA, 0, 'h20, "run tima wr");

      // TMA write during reload window updates TIMA too
      armOverflowA();
      tick(33); expectNow(0, K_TIMA, 0, 'hF0, "reload3"); expectIrq(0, 1);
      wr(0, 2, 'h55);
      expectNow(0, K_TIMA, 0, 'h55, "reload tma wr tima");
      expectNow(0, K_TMA,  0, 'h55, "reload tma wr tma");
      tick(1);

      // Glitch increments from DIV write and TAC change
      wr(0, 1, 0);
      wr(0, 0, 0);
      tick(8);  expectNow(0, K_TIMA, 0, 0, "glitch pre");
      wr(0, 0, 0); expectNow(0, K_TIMA, 0, 1, "div write glitch");
      tick(8);  expectNow(0, K_TIMA, 0, 1, "glitch pre2");
      wr(0, 3, 1);
      expectNow(0, K_TIMA, 0, 2, "tac write glitch");
      expectNow(0, K_TAC,  0, 'hF9, "tac0=1");

      // 16-bit DUT: independent rates and simultaneous wrap
      wr(1, 0, 0);
      wr(1, 3, 7);
      wr(1, 6, 5);
      wr(1, 1, 0);
      wr(1, 4, 0);
      wr(1, 2, 'h1234);
      wr(1, 5, 'hABCD);
      tick(256);
      expectNow(1, K_TIMA, 0, 1,  "B ch0 tac7");
      expectNow(1, K_TIMA, 1, 16, "B ch1 tac5");
      wr(1, 1, 'hFFFF);
      wr(1, 4, 'hFFF0);
      tick(255);
      expectNow(1, K_TIMA, 0, 'hFFFF, "B ch0 pre wrap");
      expectNow(1, K_TIMA, 1, 'hFFFF, "B ch1 pre wrap");
      tick(1);
      expectNow(1, K_TIMA, 0, 0, "B ch0 wrap");
      expectNow(1, K_TIMA, 1, 0, "B ch1 wrap");
      tick(1);
      expectNow(1, K_TIMA, 0, 'h1234, "B ch0 reload");
      expectNow(1, K_TIMA, 1, 'hABCD, "B ch1 reload");
      expectIrq(1, 3);
      expectNow(1, K_DIV, 0, 'h02, "B div");

      // Asynchronous reset with an overflow pending
      wr(0, 0, 0);
      wr(0, 3, 5);
      wr(0, 2, 'h77);
      wr(0, 4, 'h42);
      armOverflowA();
      tick(32); expectNow(0, K_TIMA, 0, 0, "pending ovf");
      iReset_n = 1'b0;
      expectNow(0, K_DIV,  0, 'hD3, "async rst div");
      expectNow(0, K_TIMA, 0, 0,    "async rst tima0");
      expectNow(0, K_TIMA, 1, 0,    "async rst tima1");
      expectNow(0, K_TMA,  0, 0,    "async rst tma0");
      expectNow(0, K_TAC,  0, 'hF8, "async rst tac0");
      expectNow(0, K_IRQ,  0, 0,    "async rst irq");
      cyc1();
      iReset_n = 1'b1;
      tick(2);  expectNow(0, K_TIMA, 0, 0, "no reload after rst");

      repeat (3) cyc1();
      if (q.size() != 0 || irqQA.size() != 0 || irqQB.size() != 0) begin
         nVec++;
         nFail++;
         $display("FAIL drain: %0d checks and %0d pulses left unserved", q.size(), irqQA.size() + irqQB.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule : tb_timer_bank
`default_nettype wire
